exec_stage: RTL
===============

# exec_stage

Execute-stage sequencer that sits directly upstream of the 8-bit ALU. It accepts decoded instructions over a valid/ready handshake, reads operands from an internal 4×8 register file, and drives the ALU's `op`/`a`/`b` inputs. It then captures `ans`/`zero` and writes the result back to the register file, or reports a branch decision for BZ.

## Interface
Parameters:
- none; the datapath is fixed at 8 bits, 4 registers, and a 3-bit opcode.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  instruction present
- `in_ready`  out  1  stage can accept an instruction
- `in_op`  in  3  opcode: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 110, BZ 111; 101 is illegal
- `in_rd`  in  2  destination register
- `in_rs`  in  2  source A register
- `in_rt`  in  2  source B register
- `in_use_imm`  in  1  1 selects `in_imm` as B instead of reg[`in_rt`]
- `in_imm`  in  8  immediate operand
- `alu_op`  out  3  registered opcode to the ALU
- `alu_a`  out  8  registered operand A to the ALU
- `alu_b`  out  8  registered operand B to the ALU
- `alu_ans`  in  8  ALU result
- `alu_zero`  in  1  ALU zero flag; meaningful only for BZ
- `wb_valid`  out  1  one-cycle pulse: result written back
- `wb_rd`  out  2  register written
- `wb_data`  out  8  value written
- `br_valid`  out  1  one-cycle pulse: BZ resolved
- `br_taken`  out  1  BZ outcome, valid with `br_valid`
- `illegal`  out  1  one-cycle pulse: opcode 101 rejected

## Operation
- **FSM states:** IDLE, EXEC, WB.
  - IDLE → EXEC on `in_valid && in_ready`.
  - EXEC → WB unconditionally.
  - WB → IDLE unconditionally.
- **Handshake:** `in_ready` = (state == IDLE) && `rst_n`. Inputs are sampled only on the accept edge. `in_valid` may drop or change at any other time without effect.
- **Accept edge:**
  - `alu_a` ← reg[`in_rs`].
  - `alu_b` ← `in_use_imm` ? `in_imm` : reg[`in_rt`].
  - `alu_op` ← `in_op`.
  - `in_rd` and `in_op` are latched internally.
- **Register r0:** reads as 0x00; writes to it are discarded.
- **Illegal opcode (101):** `alu_op` is forced to 000 (ADD) so the ALU never sees an undefined op. No writeback, no branch; `illegal` pulses in WB.
- **EXEC exit edge:** `alu_ans` → result register, `alu_zero` → flag register.
- **WB cycle:**
  - ALU ops (000–100, 110): `wb_valid` = 1, `wb_rd` = latched rd, `wb_data` = captured ans. reg[rd] is updated at the WB exit edge unless rd = 0. `wb_valid` still pulses for rd = 0.
  - BZ: `br_valid` = 1 and `br_taken` = captured zero; no register write, `wb_valid` = 0.
- **Arithmetic:** modulo 2^8 with no carry or overflow output. SLT is unsigned (0x01 or 0x00).
- **Reset (`rst_n` low at an edge, any state):**
  - state → IDLE; all registers → 0x00.
  - `alu_op`/`alu_a`/`alu_b` → 0.
  - `wb_valid`, `wb_rd`, `wb_data`, `br_valid`, `br_taken`, `illegal` → 0.
  - An in-flight instruction is dropped with no writeback.

## Timing
- Accept at edge N; EXEC during cycle N..N+1 with ALU inputs stable for that whole cycle. The ALU is combinational and must settle within one cycle.
- WB during cycle N+1..N+2, when the output pulses are high.
- Register write and return to IDLE at edge N+2 (`in_ready` high again after N+2).
- Throughput is one instruction per 3 cycles; latency from accept to `wb_valid` is 2 cycles.
- Read-after-write: the next instruction can only be accepted at edge N+3, by which point the write from N+2 is already visible. No bypass is needed.
- `wb_*`, `br_*` and `illegal` are registered outputs: high for exactly one cycle, and 0 in IDLE and EXEC.
- `alu_*` outputs hold their last value outside EXEC.

## Test plan
- **Reset:** hold `rst_n` low 2 cycles → all outputs 0 and `in_ready` 0; release → `in_ready` 1, all registers read 0.
- **ADD immediate:** ADD rd=1 rs=0 imm=0x05 → at accept+1 `alu_a`=0x00, `alu_b`=0x05; at accept+2 `wb_valid`=1, `wb_rd`=1, `wb_data`=0x05.
- **SUB wrap:** then SUB rd=2 rs=1 imm=0x07 → `wb_data`=0xFE.
- **SLT:** then SLT rd=3 rs=1 rt=2 → `wb_data`=0x01.
- **Illegal and r0 write:**
  - op 101 → `illegal` pulse; `wb_valid` and `br_valid` stay 0; registers unchanged; `alu_op` = 000.
  - ADD rd=0 imm=0x33 → `wb_valid` pulses, but a subsequent read of r0 is 0x00.
- **BZ:**
  - BZ rs=0 → `br_valid`=1, `br_taken`=1, no register change.
  - BZ rs=1 → `br_taken`=0.
- **Reset mid-EXEC:** assert `rst_n` low while in EXEC → no `wb_valid`; r1..r3 = 0x00 afterwards.
- **Stall:** hold `in_valid` high continuously → accepts are spaced exactly 3 cycles apart.

Source files
------------

// File: rtl/exec_stage.sv
// exec_stage: three-cycle execute sequencer in front of an 8-bit combinational ALU.
// An instruction is accepted in IDLE, its operands go to the ALU during EXEC, and
// the ALU result is reported and committed to the 4x8 register file during WB.
// Register r0 always reads as zero and ignores writes.

module exec_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_op,
    input  logic [1:0] in_rd,
    input  logic [1:0] in_rs,
    input  logic [1:0] in_rt,
    input  logic       in_use_imm,
    input  logic [7:0] in_imm,
    output logic [2:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_ans,
    input  logic       alu_zero,
    output logic       wb_valid,
    output logic [1:0] wb_rd,
    output logic [7:0] wb_data,
    output logic       br_valid,
    output logic       br_taken,
    output logic       illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_ILLEGAL = 3'b101;
    localparam logic [2:0] OP_BZ      = 3'b111;

    logic [1:0] state;
    logic [7:0] regs [4];
    logic [1:0] rd_q;
    logic [2:0] op_q;
    logic [7:0] read_a;
    logic [7:0] read_b;
    logic       is_bz;
    logic       is_illegal;
    logic       is_alu;

    assign in_ready   = (state == S_IDLE) && rst_n;
    assign is_bz      = (op_q == OP_BZ);
    assign is_illegal = (op_q == OP_ILLEGAL);
    assign is_alu     = !is_bz && !is_illegal;

    // Register file read ports; r0 is hardwired to zero regardless of storage.
    always_comb begin
        read_a = (in_rs == 2'd0) ? 8'h00 : regs[in_rs];
        read_b = (in_rt == 2'd0) ? 8'h00 : regs[in_rt];
    end

    // Register file write port: commits the reported result at the end of WB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (state == S_WB && wb_valid && wb_rd != 2'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Sequencer: latches the instruction on accept, captures ALU results after
    // EXEC, and drives the one-cycle WB pulses before returning to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rd_q     <= 2'd0;
            op_q     <= 3'd0;
            alu_op   <= 3'd0;
            alu_a    <= 8'h00;
            alu_b    <= 8'h00;
            wb_valid <= 1'b0;
            wb_rd    <= 2'd0;
            wb_data  <= 8'h00;
            br_valid <= 1'b0;
            br_taken <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        alu_a  <= read_a;
                        alu_b  <= in_use_imm ? in_imm : read_b;
                        alu_op <= (in_op == OP_ILLEGAL) ? OP_ADD : in_op;
                        rd_q   <= in_rd;
                        op_q   <= in_op;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wb_valid <= is_alu;
                    wb_rd    <= is_alu ? rd_q : 2'd0;
                    wb_data  <= is_alu ? alu_ans : 8'h00;
                    br_valid <= is_bz;
                    br_taken <= is_bz && alu_zero;
                    illegal  <= is_illegal;
                    state    <= S_WB;
                end
                S_WB: begin
                    wb_valid <= 1'b0;
                    wb_rd    <= 2'd0;
                    wb_data  <= 8'h00;
                    br_valid <= 1'b0;
                    br_taken <= 1'b0;
                    illegal  <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
